// File: rtl/gpc_4t_fetch_pc_gen.sv
// Round-robin PC generator/fetch sequencer for the 4-thread GPC core; issue is combinational in Q100H,
// instruction returns aligned in Q101H one cycle later; StallQ100H freezes issue but redirects still land.
module gpc_4t_fetch_pc_gen #(
   parameter int          NUM_THREADS     = 4,
   parameter logic [31:0] RESET_PC_BASE   = 32'h0000_0000,
   parameter logic [31:0] RESET_PC_STRIDE = 32'h0000_0400,
   parameter logic [31:0] NOP_INST        = 32'h0000_0013
) (
   input  logic        QClk,
   input  logic        RstQnnnH,
   input  logic [3:0]  ThreadEnableQ100H,
   input  logic        StallQ100H,
   input  logic        RedirectValidQ100H,
   input  logic [1:0]  RedirectThreadQ100H,
   input  logic [31:0] RedirectPcQ100H,
   output logic [31:0] PcQ100H,
   output logic        RdEnableQ100H,
   input  logic [31:0] InstFetchQ101H,
   output logic [31:0] InstQ101H,
   output logic [31:0] PcQ101H,
   output logic [1:0]  ThreadQ101H,
   output logic        ValidQ101H
);

   logic [31:0] pc_q [NUM_THREADS];
   logic [31:0] pc_d [NUM_THREADS];
   logic [1:0]  last_thr_q, last_thr_d;
   logic        vld_q, vld_d;
   logic [31:0] pc101_q, pc101_d;
   logic [1:0]  thr101_q, thr101_d;

   logic [1:0]  sel_thr;
   logic [1:0]  idx;
   logic        found;
   logic        any_en;
   logic        issue;
   logic        bypass;
   logic [31:0] fetch_pc;

   // Scan starts one past the last issuer so every enabled thread gets a fair turn.
   always_comb begin
      sel_thr = last_thr_q + 2'd1;
      idx     = 2'd0;
      found   = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_thr_q + 2'(k);
         if (!found && ThreadEnableQ100H[idx]) begin
            sel_thr = idx;
            found   = 1'b1;
         end
      end
   end

   assign any_en   = |ThreadEnableQ100H;
   assign issue    = any_en & ~StallQ100H & ~RstQnnnH;
   assign bypass   = RedirectValidQ100H && (RedirectThreadQ100H == sel_thr);
   assign fetch_pc = bypass ? RedirectPcQ100H : pc_q[sel_thr];

   assign PcQ100H       = RstQnnnH ? 32'h0 : fetch_pc;
   assign RdEnableQ100H = issue;

   always_comb begin
      pc_d       = pc_q;
      last_thr_d = last_thr_q;
      vld_d      = issue;
      thr101_d   = sel_thr;
      pc101_d    = pc101_q;
      if (issue) begin
         pc_d[sel_thr] = fetch_pc + 32'd4;
         last_thr_d    = sel_thr;
         pc101_d       = fetch_pc;
      end
      // A redirect already consumed by the bypass must not overwrite the advanced PC.
      if (RedirectValidQ100H && (!bypass || !issue)) begin
         pc_d[RedirectThreadQ100H] = RedirectPcQ100H;
      end
   end

   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            pc_q[i] <= RESET_PC_BASE + RESET_PC_STRIDE * 32'(i);
         end
         last_thr_q <= 2'd3;
         vld_q      <= 1'b0;
         pc101_q    <= 32'h0;
         thr101_q   <= 2'd0;
      end else begin
         pc_q       <= pc_d;
         last_thr_q <= last_thr_d;
         vld_q      <= vld_d;
         pc101_q    <= pc101_d;
         thr101_q   <= thr101_d;
      end
   end

   assign ValidQ101H  = vld_q;
   assign PcQ101H     = pc101_q;
   assign ThreadQ101H = thr101_q;
   assign InstQ101H   = vld_q ? InstFetchQ101H : NOP_INST;

endmodule

// File: tb/tb_gpc_4t_fetch_pc_gen.sv
// Directed-vector bench: stimulus checks Q100H and queues expected Q101H slots; monitor checks Q101H.
module tb_gpc_4t_fetch_pc_gen;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] SKIP = 32'hDEAD_DEAD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  en = 4'h0;
   logic        stall = 1'b0;
   logic        rv = 1'b0;
   logic [1:0]  rthr = 2'd0;
   logic [31:0] rpc = 32'h0;
   logic [31:0] pc100;
   logic        rd100;
   logic [31:0] inst_fetch = 32'h0;
   logic [31:0] inst101;
   logic [31:0] pc101;
   logic [1:0]  thr101;
   logic        vld101;

   int checks = 0;
   int failures = 0;
   logic mon_on = 1'b0;
   logic [33:0] exp_q [$];

   always #5 clk = ~clk;

   gpc_4t_fetch_pc_gen dut (
      .QClk(clk), .RstQnnnH(rst), .ThreadEnableQ100H(en), .StallQ100H(stall),
      .RedirectValidQ100H(rv), .RedirectThreadQ100H(rthr), .RedirectPcQ100H(rpc),
      .PcQ100H(pc100), .RdEnableQ100H(rd100), .InstFetchQ101H(inst_fetch),
      .InstQ101H(inst101), .PcQ101H(pc101), .ThreadQ101H(thr101), .ValidQ101H(vld101)
   );

   // Memory model: returns the bit-inverted address one cycle after the read.
   always @(posedge clk) inst_fetch <= ~pc100;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic s_rst, input logic [3:0] s_en, input logic s_stall,
                       input logic s_rv, input logic [1:0] s_rthr, input logic [31:0] s_rpc,
                       input logic exp_rd, input logic [31:0] exp_pc, input logic [1:0] exp_thr);
      @(negedge clk);
      rst = s_rst; en = s_en; stall = s_stall; rv = s_rv; rthr = s_rthr; rpc = s_rpc;
      #1;
      chk("rd_enable", {31'h0, rd100}, {31'h0, exp_rd});
      if (exp_pc != SKIP) chk("pc_q100", pc100, exp_pc);
      if (exp_rd) exp_q.push_back({exp_thr, exp_pc});
   endtask

   initial begin : monitor
      logic [33:0] e;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (vld101) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_valid: pc %h thr %0d with no expected slot", pc101, thr101);
               end else begin
                  e = exp_q.pop_front();
                  chk("pc_q101", pc101, e[31:0]);
                  chk("thread_q101", {30'h0, thr101}, {30'h0, e[33:32]});
                  chk("inst_q101", inst101, ~e[31:0]);
               end
            end else begin
               chk("inst_nop", inst101, NOP);
            end
         end
      end
   end

   initial begin : stimulus
      step(1, 4'hF, 0, 0, 0, 0, 0, 32'h0, 0);
      step(1, 4'hF, 0, 0, 0, 0, 0, 32'h0, 0);
      mon_on = 1'b1;
      // All four threads, round robin from thread 0
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h000, 0);
      chk("rst_valid", {31'h0, vld101}, 32'h0);
      chk("rst_pc101", pc101, 32'h0);
      chk("rst_thr101", {30'h0, thr101}, 32'h0);
      chk("rst_inst", inst101, NOP);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h400, 1);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h800, 2);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'hC00, 3);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h004, 0);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h404, 1);
      // Threads 0 and 2 only
      step(0, 4'h5, 0, 0, 0, 0, 1, 32'h804, 2);
      step(0, 4'h5, 0, 0, 0, 0, 1, 32'h008, 0);
      step(0, 4'h5, 0, 0, 0, 0, 1, 32'h808, 2);
      step(0, 4'h5, 0, 0, 0, 0, 1, 32'h00C, 0);
      // Same-cycle redirect bypass on thread 1
      step(0, 4'hF, 0, 1, 1, 32'h1234_5678, 1, 32'h1234_5678, 1);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h80C, 2);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'hC04, 3);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h010, 0);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h1234_567C, 1);
      // Stall with a redirect of thread 2 landing mid-stall
      step(0, 4'hF, 1, 0, 0, 0, 0, 32'h810, 0);
      step(0, 4'hF, 1, 1, 2, 32'h2000, 0, 32'h2000, 0);
      step(0, 4'hF, 1, 0, 0, 0, 0, 32'h2000, 0);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h2000, 2);
      // Redirect of a non-selected thread while issuing
      step(0, 4'hF, 0, 1, 0, 32'h500, 1, 32'hC08, 3);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h500, 0);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h1234_5680, 1);
      // No thread enabled; redirect still stored
      step(0, 4'h0, 0, 0, 0, 0, 0, SKIP, 0);
      step(0, 4'h0, 0, 1, 0, 32'hFFFF_FFFC, 0, SKIP, 0);
      step(0, 4'h0, 0, 0, 0, 0, 0, SKIP, 0);
      // Single thread issues every cycle and wraps
      step(0, 4'h1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      step(0, 4'h1, 0, 0, 0, 0, 1, 32'h0000_0000, 0);
      step(0, 4'h1, 0, 0, 0, 0, 1, 32'h0000_0004, 0);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h1234_5684, 1);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h2004, 2);
      // Mid-stream reset drops the in-flight slot and restores reset PCs
      step(1, 4'hF, 0, 0, 0, 0, 0, 32'h0, 0);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h000, 0);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h400, 1);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'h800, 2);
      step(0, 4'hF, 0, 0, 0, 0, 1, 32'hC00, 3);
      step(0, 4'h0, 0, 0, 0, 0, 0, SKIP, 0);
      step(0, 4'h0, 0, 0, 0, 0, 0, SKIP, 0);
      @(negedge clk);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
